clint: RTL and testbench
========================

# clint

Core-local interruptor: memory-mapped responder at `clint_base_addr`..`clint_top_addr` on the core data bus. Owns the 64-bit `mtime` counter (advanced by an RTC tick divided from `clock`), `mtimecmp` and `msip`, and drives the machine timer and software interrupt lines into the core CSR unit. It is the responder side of the core's memory request interface; the address decoder routes CLINT-range requests here.

## Interface
- `clk_divider_rtc`, default `configure::clk_divider_rtc` (4): half-period of the RTC in `clock` cycles, minus 1.
- `reset`  in  1  asynchronous, active-high reset.
- `clock`  in  1  core clock.
- `mem_valid`  in  1  request strobe, one cycle per request.
- `mem_instr`  in  1  fetch request; treated as a read, no side effects.
- `mem_addr`  in  32  byte address; only `mem_addr[15:2]` is decoded.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; nonzero means write, zero means read.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `mem_ready`  out  1  response strobe.
- `mtime`  out  64  current counter value, for the `time` CSR.
- `m_soft_irq`  out  1  `msip[0]`.
- `m_timer_irq`  out  1  registered `mtime >= mtimecmp`, unsigned.

## Operation
- Register map (offsets from base): `msip` 0x0000 (bit 0 only, others read 0); `mtimecmp` lo 0x4000, hi 0x4004; `mtime` lo 0xBFF8, hi 0xBFFC. Other offsets read 0, writes are ignored, and `mem_ready` still responds.
- Writes are byte-granular per `mem_wstrb`. A read returns the register value before any same-cycle update.
- RTC divider: counter `div_cnt` counts 0..`clk_divider_rtc` and wraps to 0. `rtc_phase` toggles on each wrap. `mtime` increments by 1 in the cycle the toggle makes `rtc_phase` go 0→1. Increment period is 2·(`clk_divider_rtc`+1) clocks, i.e. 10 at default.
- `mtime` wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0. No carry-out flag.
- Write to `mtime` (either half) in a tick cycle: the write takes effect and the tick's increment is dropped for the whole 64-bit value. The divider does not stall.
- `m_timer_irq` is recomputed every cycle from the registered `mtime`/`mtimecmp` and does not latch. A write of a larger `mtimecmp` clears it one cycle after the register updates.
- Reset values: `mem_ready`=0, `mem_rdata`=0, `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `m_soft_irq`=0, `m_timer_irq`=0, `div_cnt`=0, `rtc_phase`=0.
- Reset asserted mid-request: the pending response is discarded and `mem_ready` stays 0 after reset deasserts.

## Timing
- Fixed one-cycle latency: `mem_valid` in cycle N gives `mem_ready`=1 with `mem_rdata` in cycle N+1.
- No backpressure and no busy state; `mem_valid` may be asserted every cycle, and each request gets exactly one `mem_ready` pulse.
- Register writes are visible in cycle N+1. `m_timer_irq` and `m_soft_irq` reflect the write in cycle N+2.
- First `mtime` increment after reset release: `div_cnt` wraps at the end of clock 5 (default), so `mtime`=1 from clock 6. Subsequent increments follow every 10 clocks.

## Structure
- Add constants `clint_msip_off`, `clint_mtimecmp_off`, `clint_mtime_off` (16-bit offsets) to `configure` next to `clint_base_addr`/`clint_top_addr`.
- One sub-module, `clint_rtc_div`: divider counter plus phase, output `rtc_tick` (one-cycle pulse), parameter `clk_divider_rtc`.
- `clint` holds the decode, the registers, the response register and the compare.

## Test plan
- Reset release, idle 25 clocks: `mtime` reads 2 at clock 25, `m_timer_irq`=0, `m_soft_irq`=0, and reads of 0x4000/0x4004 return 0xFFFFFFFF.
- Write 0x0000 ← 1 with strobe 0xF: `mem_ready` one cycle later, `m_soft_irq`=1 two cycles after the request. Write 0 and it clears.
- Write `mtimecmp` hi ← 0, lo ← 3: `m_timer_irq` rises two clocks after `mtime` reaches 3. Then write lo ← 0xFFFFFFFF and it falls.
- Write `mtime` lo ← 0xFFFFFFFF, hi ← 0xFFFFFFFF, then wait one tick: `mtime`=0 and `m_timer_irq` follows the compare.
- Back-to-back reads of 0xBFF8, 0xBFFC, 0x1234 on consecutive cycles: three consecutive `mem_ready` pulses, the last with data 0. Also issue a byte write to 0x4001 with strobe 0x2 and check that only byte 1 changes.
- Assert `reset` the cycle after a `mem_valid`: no `mem_ready`, and all outputs return to their reset values.

Source files
------------

// File: rtl/configure.sv
// rtl/configure.sv - shared configuration constants, CLINT register decode and byte-merge helpers
package configure;

  // RTC half-period in core clocks, minus one
  localparam int unsigned clk_divider_rtc = 4;

  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr  = 32'h0200_ffff;

  localparam logic [15:0] clint_msip_off     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
  localparam logic [15:0] clint_mtime_off    = 16'hbff8;

  typedef enum logic [2:0] {
    reg_none,
    reg_msip,
    reg_cmp_lo,
    reg_cmp_hi,
    reg_time_lo,
    reg_time_hi
  } clint_reg_e;

  // Word-aligned offset decode; anything unmapped falls to reg_none
  function automatic clint_reg_e decode_reg(input logic [13:0] word_addr);
    logic [15:0] off;
    off = {word_addr, 2'b00};
    decode_reg = reg_none;
    if (off == clint_msip_off)                    decode_reg = reg_msip;
    else if (off == clint_mtimecmp_off)           decode_reg = reg_cmp_lo;
    else if (off == clint_mtimecmp_off + 16'd4)   decode_reg = reg_cmp_hi;
    else if (off == clint_mtime_off)              decode_reg = reg_time_lo;
    else if (off == clint_mtime_off + 16'd4)      decode_reg = reg_time_hi;
  endfunction

  // Replace only the byte lanes enabled in strb
  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
    for (int i = 0; i < 4; i++) begin
      merge_bytes[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/clint_rtc_div.sv
// rtl/clint_rtc_div.sv - RTC divider producing a one-cycle mtime increment pulse
module clint_rtc_div #(
  parameter int unsigned clk_divider_rtc = configure::clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic rtc_tick
);

  localparam int cnt_w = (clk_divider_rtc < 1) ? 1 : $clog2(clk_divider_rtc + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(clk_divider_rtc);

  logic [cnt_w-1:0] div_cnt;
  logic             rtc_phase;
  logic             cnt_wrap;

  assign cnt_wrap = (div_cnt == cnt_last);

  // The tick is the wrap that moves rtc_phase from 0 to 1, so it lands in
  // the same cycle as that edge of the RTC rather than one cycle later.
  assign rtc_tick = cnt_wrap & ~rtc_phase;

  // Half-period counter and RTC phase; the phase flips on every wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      rtc_phase <= 1'b0;
    end else if (cnt_wrap) begin
      div_cnt   <= '0;
      rtc_phase <= ~rtc_phase;
    end else begin
      div_cnt   <= div_cnt + cnt_w'(1);
    end
  end

endmodule

// File: rtl/clint.sv
// rtl/clint.sv - core-local interruptor: mtime/mtimecmp/msip registers and interrupt lines
module clint
  import configure::*;
#(
  parameter int unsigned clk_divider_rtc = configure::clk_divider_rtc
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic [63:0] mtime,
  output logic        m_soft_irq,
  output logic        m_timer_irq
);

  logic [63:0] mtime_q;
  logic [63:0] mtimecmp_q;
  logic        msip_q;
  logic        rtc_tick;
  clint_reg_e  sel;
  logic        wr_en;
  logic [31:0] rd_word;
  logic        unused_addr_bits;

  // The address decoder upstream already qualified the range, so the upper
  // bits and the byte offset carry no information here.
  assign unused_addr_bits = ^{mem_addr[31:16], mem_addr[1:0]};

  assign sel   = decode_reg(mem_addr[15:2]);
  assign wr_en = mem_valid & ~mem_instr & (|mem_wstrb);
  assign mtime = mtime_q;

  clint_rtc_div #(
    .clk_divider_rtc(clk_divider_rtc)
  ) u_rtc_div (
    .clock   (clock),
    .reset   (reset),
    .rtc_tick(rtc_tick)
  );

  // Read mux over the current register values (before any same-cycle write)
  always_comb begin
    rd_word = '0;
    case (sel)
      reg_msip:    rd_word = {31'b0, msip_q};
      reg_cmp_lo:  rd_word = mtimecmp_q[31:0];
      reg_cmp_hi:  rd_word = mtimecmp_q[63:32];
      reg_time_lo: rd_word = mtime_q[31:0];
      reg_time_hi: rd_word = mtime_q[63:32];
      default:     rd_word = '0;
    endcase
  end

  // Single-cycle response: every request gets exactly one ready pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= mem_valid;
      mem_rdata <= mem_valid ? rd_word : 32'h0;
    end
  end

  // mtime: a bus write to either half wins over the RTC tick for all 64 bits
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime_q <= '0;
    end else if (wr_en && sel == reg_time_lo) begin
      mtime_q[31:0] <= merge_bytes(mtime_q[31:0], mem_wdata, mem_wstrb);
    end else if (wr_en && sel == reg_time_hi) begin
      mtime_q[63:32] <= merge_bytes(mtime_q[63:32], mem_wdata, mem_wstrb);
    end else if (rtc_tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  // mtimecmp and msip byte-granular writes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
    end else if (wr_en) begin
      case (sel)
        reg_cmp_lo: mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0], mem_wdata, mem_wstrb);
        reg_cmp_hi: mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], mem_wdata, mem_wstrb);
        reg_msip:   if (mem_wstrb[0]) msip_q <= mem_wdata[0];
        default:    ;
      endcase
    end
  end

  // Interrupt lines are registered copies of the current register state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_timer_irq <= 1'b0;
      m_soft_irq  <= 1'b0;
    end else begin
      m_timer_irq <= (mtime_q >= mtimecmp_q);
      m_soft_irq  <= msip_q;
    end
  end

endmodule

// File: tb/tb_clint.sv
// tb/tb_clint.sv - directed self-checking bench for clint
module tb_clint;

  logic        reset;
  logic        clock;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [63:0] mtime;
  logic        m_soft_irq;
  logic        m_timer_irq;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  clint dut (
    .reset      (reset),
    .clock      (clock),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mtime      (mtime),
    .m_soft_irq (m_soft_irq),
    .m_timer_irq(m_timer_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Posedges since reset release; tick edges are cyc = 5, 15, 25, ...
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        is_read;
    logic [31:0] exp_rdata;
  } b2b_t;

  vec_t vecs[16];
  b2b_t b2b[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic req_drive(input logic instr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = strb;
  endtask

  task automatic req_idle;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
  endtask

  // Called at a negedge: one request, response checked at the next negedge
  task automatic req_single(input string name, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic chk_data, input logic [31:0] exp);
    req_drive(instr, addr, wdata, strb);
    @(negedge clock);
    req_idle();
    chk({name, ".ready"}, 64'(mem_ready), 64'd1);
    if (chk_data) chk({name, ".rdata"}, 64'(mem_rdata), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    req_idle();

    vecs[0]  = '{1'b0, 32'h0200_4000, 32'h0,          4'h0, 32'hffff_ffff};
    vecs[1]  = '{1'b0, 32'h0200_4004, 32'h0,          4'h0, 32'hffff_ffff};
    vecs[2]  = '{1'b0, 32'h0200_0000, 32'h0,          4'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 32'h0200_0000, 32'hffff_ffff,  4'hf, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0200_0000, 32'h0,          4'h0, 32'h0000_0001};
    vecs[5]  = '{1'b0, 32'h0200_4001, 32'h0000_ab00,  4'h2, 32'hffff_ffff};
    vecs[6]  = '{1'b0, 32'h0200_4000, 32'h0,          4'h0, 32'hffff_abff};
    vecs[7]  = '{1'b0, 32'h0200_4004, 32'h1234_5678,  4'h5, 32'hffff_ffff};
    vecs[8]  = '{1'b0, 32'h0200_4004, 32'h0,          4'h0, 32'hff34_ff78};
    vecs[9]  = '{1'b0, 32'h0200_1234, 32'h0000_0005,  4'hf, 32'h0000_0000};
    vecs[10] = '{1'b0, 32'h0200_1234, 32'h0,          4'h0, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h0200_0000, 32'h0,          4'he, 32'h0000_0001};
    vecs[12] = '{1'b0, 32'h0200_0000, 32'h0,          4'h0, 32'h0000_0001};
    vecs[13] = '{1'b0, 32'h0200_0000, 32'h0,          4'hf, 32'h0000_0001};
    vecs[14] = '{1'b1, 32'h0200_0000, 32'h1,          4'hf, 32'h0000_0000};
    vecs[15] = '{1'b0, 32'h0200_0000, 32'h0,          4'h0, 32'h0000_0000};

    b2b[0] = '{32'h0200_bff8, 32'h1234_5678, 4'hf, 1'b0, 32'h0};
    b2b[1] = '{32'h0200_bffc, 32'h9abc_def0, 4'hf, 1'b0, 32'h0};
    b2b[2] = '{32'h0200_bff8, 32'h0,         4'h0, 1'b1, 32'h1234_5678};
    b2b[3] = '{32'h0200_bffc, 32'h0,         4'h0, 1'b1, 32'h9abc_def0};
    b2b[4] = '{32'h0200_1234, 32'h0,         4'h0, 1'b1, 32'h0};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst.ready", 64'(mem_ready), 64'd0);
    chk("rst.rdata", 64'(mem_rdata), 64'd0);
    chk("rst.mtime", mtime, 64'd0);
    chk("rst.soft", 64'(m_soft_irq), 64'd0);
    chk("rst.timer", 64'(m_timer_irq), 64'd0);
    reset = 1'b0;

    // Idle to clock 24, then read mtime lo during clock 25
    while (cyc < 24) @(negedge clock);
    req_single("idle_mtime", 1'b0, 32'h0200_bff8, 32'h0, 4'h0, 1'b1, 32'd2);
    chk("idle.mtime_after25", mtime, 64'd3);
    chk("idle.timer", 64'(m_timer_irq), 64'd0);
    chk("idle.soft", 64'(m_soft_irq), 64'd0);

    // Register vectors
    for (int i = 0; i < 16; i++) begin
      req_single($sformatf("vec%0d", i), vecs[i].instr, vecs[i].addr, vecs[i].wdata,
                 vecs[i].wstrb, 1'b1, vecs[i].exp_rdata);
    end

    // Software interrupt: visible two cycles after the request
    req_drive(1'b0, 32'h0200_0000, 32'h1, 4'hf);
    @(negedge clock);
    req_idle();
    chk("soft_set.ready", 64'(mem_ready), 64'd1);
    chk("soft_set.n1", 64'(m_soft_irq), 64'd0);
    @(negedge clock);
    chk("soft_set.n2", 64'(m_soft_irq), 64'd1);
    req_drive(1'b0, 32'h0200_0000, 32'h0, 4'hf);
    @(negedge clock);
    req_idle();
    chk("soft_clr.n1", 64'(m_soft_irq), 64'd1);
    @(negedge clock);
    chk("soft_clr.n2", 64'(m_soft_irq), 64'd0);

    // Timer compare: rewind mtime, set mtimecmp = 3
    req_single("tm.time_hi", 1'b0, 32'h0200_bffc, 32'h0, 4'hf, 1'b0, 32'h0);
    req_single("tm.time_lo", 1'b0, 32'h0200_bff8, 32'h0, 4'hf, 1'b0, 32'h0);
    req_single("tm.cmp_hi", 1'b0, 32'h0200_4004, 32'h0, 4'hf, 1'b0, 32'h0);
    req_single("tm.cmp_lo", 1'b0, 32'h0200_4000, 32'h3, 4'hf, 1'b0, 32'h0);
    chk("tm.cmp_readback_hi_lo", 64'(m_timer_irq), 64'd0);
    k = 0;
    while (mtime != 64'd3 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("tm.reach3", mtime, 64'd3);
    chk("tm.irq_at_reach", 64'(m_timer_irq), 64'd0);
    @(negedge clock);
    chk("tm.irq_rise", 64'(m_timer_irq), 64'd1);
    req_drive(1'b0, 32'h0200_4000, 32'hffff_ffff, 4'hf);
    @(negedge clock);
    req_idle();
    chk("tm.cmp_up.n1", 64'(m_timer_irq), 64'd1);
    @(negedge clock);
    chk("tm.cmp_up.n2", 64'(m_timer_irq), 64'd0);

    // mtime wrap; the lo write lands on a tick edge and suppresses the increment
    while ((cyc % 10) != 4) @(negedge clock);
    req_drive(1'b0, 32'h0200_bff8, 32'hffff_ffff, 4'hf);
    @(negedge clock);
    chk("wrap.lo_write_drops_tick", mtime, 64'h0000_0000_ffff_ffff);
    req_drive(1'b0, 32'h0200_bffc, 32'hffff_ffff, 4'hf);
    @(negedge clock);
    req_idle();
    chk("wrap.all_ones", mtime, 64'hffff_ffff_ffff_ffff);
    while ((cyc % 10) != 4) @(negedge clock);
    chk("wrap.hold", mtime, 64'hffff_ffff_ffff_ffff);
    chk("wrap.irq_hi", 64'(m_timer_irq), 64'd1);
    @(negedge clock);
    chk("wrap.zero", mtime, 64'd0);
    chk("wrap.irq_lag", 64'(m_timer_irq), 64'd1);
    @(negedge clock);
    chk("wrap.irq_lo", 64'(m_timer_irq), 64'd0);

    // Back-to-back requests between ticks
    for (int i = 0; i < 5; i++) begin
      req_drive(1'b0, b2b[i].addr, b2b[i].wdata, b2b[i].wstrb);
      @(negedge clock);
      chk($sformatf("b2b%0d.ready", i), 64'(mem_ready), 64'd1);
      if (b2b[i].is_read) chk($sformatf("b2b%0d.rdata", i), 64'(mem_rdata), 64'(b2b[i].exp_rdata));
    end
    req_idle();
    chk("b2b.mtime", mtime, 64'h9abc_def0_1234_5678);
    @(negedge clock);
    chk("b2b.ready_drop", 64'(mem_ready), 64'd0);

    // Reset during a pending response
    req_single("mr.msip", 1'b0, 32'h0200_0000, 32'h1, 4'hf, 1'b0, 32'h0);
    @(negedge clock);
    chk("mr.soft_pre", 64'(m_soft_irq), 64'd1);
    req_drive(1'b0, 32'h0200_4000, 32'h0, 4'h0);
    @(negedge clock);
    req_idle();
    reset = 1'b1;
    #1;
    chk("mr.ready", 64'(mem_ready), 64'd0);
    chk("mr.rdata", 64'(mem_rdata), 64'd0);
    chk("mr.mtime", mtime, 64'd0);
    chk("mr.soft", 64'(m_soft_irq), 64'd0);
    chk("mr.timer", 64'(m_timer_irq), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("mr.idle%0d", i), 64'(mem_ready), 64'd0);
    end
    req_single("mr.cmp_lo", 1'b0, 32'h0200_4000, 32'h0, 4'h0, 1'b1, 32'hffff_ffff);
    req_single("mr.cmp_hi", 1'b0, 32'h0200_4004, 32'h0, 4'h0, 1'b1, 32'hffff_ffff);
    req_single("mr.msip_rd", 1'b0, 32'h0200_0000, 32'h0, 4'h0, 1'b1, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
